// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // MDU occupancy FSM: RUN is normal flow, MDU holds EX for a mult/div
  typedef enum logic {
    RUN = 1'b0,
    MDU = 1'b1
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, stage enables/flushes out.
// master drives the pipeline status, slave is the controller.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [REG_W-1:0] ex_rd;
  logic             ex_branch_taken;
  logic             ex_mdu_start;
  logic             mem_access;
  logic             dmem_ready;
  logic             imem_ready;

  logic             pc_ce;
  logic             ifid_ce;
  logic             ifid_flush;
  logic             idex_ce;
  logic             idex_flush;
  logic             exmem_ce;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             mdu_busy;
  logic             mdu_done;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write,
           ex_rd, ex_branch_taken, ex_mdu_start, mem_access, dmem_ready,
           imem_ready,
    input  pc_ce, ifid_ce, ifid_flush, idex_ce, idex_flush, exmem_ce,
           exmem_flush, memwb_flush, mdu_busy, mdu_done, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write,
           ex_rd, ex_branch_taken, ex_mdu_start, mem_access, dmem_ready,
           imem_ready,
    output pc_ce, ifid_ce, ifid_flush, idex_ce, idex_flush, exmem_ce,
           exmem_flush, memwb_flush, mdu_busy, mdu_done, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load in EX is about to write. Pure combinational; also reused by forwarding.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  logic rs_hit;
  logic rt_hit;

  // r0 is hardwired, so a load targeting it never creates a dependency
  always_comb begin
    rs_hit   = id_uses_rs & (id_rs == ex_rd);
    rt_hit   = id_uses_rt & (id_rt == ex_rd);
    load_use = ex_mem_read & ex_reg_write & (ex_rd != REG_ZERO) & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. A fixed priority
// mux (dmem wait > MDU > branch > load-use > imem wait) picks the stage
// enables/flushes; a two-state FSM tracks MDU occupancy of EX.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
)(
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int CW = $clog2(MDU_LAT + 1);

  hz_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] stall_q;

  logic load_use;
  logic dmem_stall;
  logic mdu_stall;

  hazard_detect u_hazard_detect (
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .id_uses_rs   (bus.id_uses_rs),
    .id_uses_rt   (bus.id_uses_rt),
    .ex_mem_read  (bus.ex_mem_read),
    .ex_reg_write (bus.ex_reg_write),
    .ex_rd        (bus.ex_rd),
    .load_use     (load_use)
  );

  // done_q masks ex_mdu_start so the finished op leaves EX without restarting
  always_comb begin
    dmem_stall = bus.mem_access & ~bus.dmem_ready;
    mdu_stall  = (state_q == MDU) |
                 ((state_q == RUN) & bus.ex_mdu_start & ~done_q);
  end

  // Priority mux: only the highest active hazard shapes the outputs
  always_comb begin
    bus.pc_ce       = 1'b1;
    bus.ifid_ce     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_ce     = 1'b1;
    bus.idex_flush  = 1'b0;
    bus.exmem_ce    = 1'b1;
    bus.exmem_flush = 1'b0;
    bus.memwb_flush = 1'b0;
    if (rst) begin
      bus.pc_ce       = 1'b0;
      bus.ifid_ce     = 1'b0;
      bus.idex_ce     = 1'b0;
      bus.exmem_ce    = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.exmem_flush = 1'b1;
      bus.memwb_flush = 1'b1;
    end else if (dmem_stall) begin
      // freeze everything up to MEM; the MEM op must not retire twice
      bus.pc_ce       = 1'b0;
      bus.ifid_ce     = 1'b0;
      bus.idex_ce     = 1'b0;
      bus.exmem_ce    = 1'b0;
      bus.memwb_flush = 1'b1;
    end else if (mdu_stall) begin
      // EX is occupied; feed MEM bubbles while the front end waits
      bus.pc_ce       = 1'b0;
      bus.ifid_ce     = 1'b0;
      bus.idex_ce     = 1'b0;
      bus.exmem_flush = 1'b1;
    end else if (bus.ex_branch_taken) begin
      // redirect always loads the PC, even with a pending fetch
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
    end else if (load_use) begin
      bus.pc_ce       = 1'b0;
      bus.ifid_ce     = 1'b0;
      bus.idex_flush  = 1'b1;
    end else if (!bus.imem_ready) begin
      bus.pc_ce       = 1'b0;
      bus.ifid_flush  = 1'b1;
    end
  end

  // MDU FSM next-state: countdown from MDU_LAT-1, frozen by dmem waits
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (!dmem_stall) begin
      done_d = 1'b0;
      unique case (state_q)
        RUN: begin
          if (bus.ex_mdu_start && !done_q) begin
            state_d = MDU;
            cnt_d   = CW'(MDU_LAT - 1);
          end
        end
        MDU: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // FSM state register; reset drops any in-flight op without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Saturating count of front-end stall cycles
  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (!bus.pc_ce && (stall_q != {CNT_W{1'b1}}))
      stall_q <= stall_q + CNT_W'(1);
  end

  // Status outputs
  always_comb begin
    bus.mdu_busy     = (state_q == MDU);
    bus.mdu_done     = done_q & ~rst;
    bus.stall_cycles = stall_q;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. A second instance with CNT_W=3 shares
// the same stimulus to exercise counter saturation.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  // control vector: {pc_ce, ifid_ce, ifid_flush, idex_ce, idex_flush,
  //                  exmem_ce, exmem_flush, memwb_flush}
  localparam logic [7:0] C_IDLE = 8'b1101_0100;
  localparam logic [7:0] C_RST  = 8'b0010_1011;
  localparam logic [7:0] C_DMEM = 8'b0000_0001;
  localparam logic [7:0] C_MDU  = 8'b0000_0110;
  localparam logic [7:0] C_BR   = 8'b1111_1100;
  localparam logic [7:0] C_LU   = 8'b0001_1100;
  localparam logic [7:0] C_IMEM = 8'b0111_0100;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(32)) ifm ();
  pipe_hazard_ctrl_if #(.CNT_W(3))  ifs ();

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(32)) u_dut (.clk(clk), .rst(rst), .bus(ifm));
  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(3))  u_sat (.clk(clk), .rst(rst), .bus(ifs));

  assign ifs.id_rs           = ifm.id_rs;
  assign ifs.id_rt           = ifm.id_rt;
  assign ifs.id_uses_rs      = ifm.id_uses_rs;
  assign ifs.id_uses_rt      = ifm.id_uses_rt;
  assign ifs.ex_mem_read     = ifm.ex_mem_read;
  assign ifs.ex_reg_write    = ifm.ex_reg_write;
  assign ifs.ex_rd           = ifm.ex_rd;
  assign ifs.ex_branch_taken = ifm.ex_branch_taken;
  assign ifs.ex_mdu_start    = ifm.ex_mdu_start;
  assign ifs.mem_access      = ifm.mem_access;
  assign ifs.dmem_ready      = ifm.dmem_ready;
  assign ifs.imem_ready      = ifm.imem_ready;

  logic [7:0] ctl;
  assign ctl = {ifm.pc_ce, ifm.ifid_ce, ifm.ifid_flush, ifm.idex_ce,
                ifm.idex_flush, ifm.exmem_ce, ifm.exmem_flush, ifm.memwb_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock, then leave time for new inputs before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifm.id_rs = '0; ifm.id_rt = '0; ifm.id_uses_rs = 0; ifm.id_uses_rt = 0;
    ifm.ex_mem_read = 0; ifm.ex_reg_write = 0; ifm.ex_rd = '0;
    ifm.ex_branch_taken = 0; ifm.ex_mdu_start = 0;
    ifm.mem_access = 0; ifm.dmem_ready = 1; ifm.imem_ready = 1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #2;
    // reset
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_busy", 32'(ifm.mdu_busy), 0);
    chk("rst_done", 32'(ifm.mdu_done), 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("idle_ctl", 32'(ctl), 32'(C_IDLE));
    chk("idle_stall", ifm.stall_cycles, 0);

    // load-use on rs
    ifm.ex_mem_read = 1; ifm.ex_reg_write = 1; ifm.ex_rd = 5'd8;
    ifm.id_rs = 5'd8; ifm.id_uses_rs = 1;
    #1;
    chk("lu_ctl", 32'(ctl), 32'(C_LU));
    tick();
    ifm.ex_rd = 5'd0; ifm.id_rs = 5'd0;
    #1;
    chk("lu_r0_ctl", 32'(ctl), 32'(C_IDLE));
    chk("lu_stall", ifm.stall_cycles, 1);
    ifm.ex_rd = 5'd8; ifm.id_rs = 5'd8; ifm.ex_reg_write = 0;
    #1;
    chk("lu_nowr_ctl", 32'(ctl), 32'(C_IDLE));
    idle_inputs();

    // MDU op, ex_mdu_start held until the done cycle
    tick();
    ifm.ex_mdu_start = 1;
    #1;
    chk("mdu_c1_ctl", 32'(ctl), 32'(C_MDU));
    chk("mdu_c1_busy", 32'(ifm.mdu_busy), 0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("mdu_c%0d_ctl", i), 32'(ctl), 32'(C_MDU));
      chk($sformatf("mdu_c%0d_busy", i), 32'(ifm.mdu_busy), 1);
      chk($sformatf("mdu_c%0d_done", i), 32'(ifm.mdu_done), 0);
    end
    tick();
    chk("mdu_c5_ctl", 32'(ctl), 32'(C_IDLE));
    chk("mdu_c5_done", 32'(ifm.mdu_done), 1);
    chk("mdu_c5_busy", 32'(ifm.mdu_busy), 0);
    chk("mdu_c5_stall", ifm.stall_cycles, 5);
    tick();
    ifm.ex_mdu_start = 0;
    #1;
    chk("mdu_c6_ctl", 32'(ctl), 32'(C_IDLE));
    chk("mdu_c6_done", 32'(ifm.mdu_done), 0);

    // branch beats load-use and imem wait
    ifm.ex_branch_taken = 1; ifm.imem_ready = 0;
    ifm.ex_mem_read = 1; ifm.ex_reg_write = 1; ifm.ex_rd = 5'd8;
    ifm.id_rt = 5'd8; ifm.id_uses_rt = 1;
    #1;
    chk("br_ctl", 32'(ctl), 32'(C_BR));
    tick();
    idle_inputs();
    #1;
    chk("br_stall", ifm.stall_cycles, 5);

    // dmem wait for 3 cycles in the middle of an MDU op
    ifm.ex_mdu_start = 1;
    #1;
    chk("md_c1_ctl", 32'(ctl), 32'(C_MDU));
    tick(); tick();
    ifm.mem_access = 1; ifm.dmem_ready = 0;
    #1;
    for (int i = 3; i <= 5; i++) begin
      chk($sformatf("md_c%0d_ctl", i), 32'(ctl), 32'(C_DMEM));
      chk($sformatf("md_c%0d_busy", i), 32'(ifm.mdu_busy), 1);
      tick();
    end
    ifm.mem_access = 0; ifm.dmem_ready = 1;
    #1;
    chk("md_c6_ctl", 32'(ctl), 32'(C_MDU));
    chk("md_c6_busy", 32'(ifm.mdu_busy), 1);
    tick();
    chk("md_c7_ctl", 32'(ctl), 32'(C_MDU));
    chk("md_c7_done", 32'(ifm.mdu_done), 0);
    tick();
    chk("md_c8_ctl", 32'(ctl), 32'(C_IDLE));
    chk("md_c8_done", 32'(ifm.mdu_done), 1);
    tick();
    ifm.ex_mdu_start = 0;
    #1;
    chk("md_stall", ifm.stall_cycles, 12);

    // reset during MDU state
    ifm.ex_mdu_start = 1;
    tick();
    chk("rm_busy", 32'(ifm.mdu_busy), 1);
    rst = 1'b1; ifm.ex_mdu_start = 0;
    #1;
    chk("rm_ctl", 32'(ctl), 32'(C_RST));
    chk("rm_done_in", 32'(ifm.mdu_done), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rm_busy_after", 32'(ifm.mdu_busy), 0);
    chk("rm_done_after", 32'(ifm.mdu_done), 0);
    chk("rm_ctl_after", 32'(ctl), 32'(C_IDLE));
    tick();
    chk("rm_done_late", 32'(ifm.mdu_done), 0);

    // saturation of the 3-bit counter on fetch stalls
    ifm.imem_ready = 0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("sat_ctl_%0d", i), 32'(ctl), 32'(C_IMEM));
      chk($sformatf("sat_wide_%0d", i), ifm.stall_cycles, 32'(i));
      chk($sformatf("sat_narrow_%0d", i), 32'(ifs.stall_cycles), (i > 7) ? 32'd7 : 32'(i));
      tick();
    end
    ifm.imem_ready = 1;
    #1;
    chk("sat_wide_end", ifm.stall_cycles, 10);
    chk("sat_narrow_end", 32'(ifs.stall_cycles), 7);
    tick();
    chk("sat_narrow_hold", 32'(ifs.stall_cycles), 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline. It drives the clock-enable and synchronous-flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves five hazard classes under one fixed priority: data-memory wait, multi-cycle MDU op, taken branch, load-use, instruction-memory wait.
- Contains a small FSM with a countdown for MDU occupancy, plus a saturating stall-cycle counter.

Parameters:
- MDU_LAT, 4: stall cycles per MDU op; legal range ≥2.
- CNT_W, 32: width of stall_cycles.

Ports:
- clk  in  1  Pipeline clock.
- rst  in  1  Synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  The ID instruction reads rs.
- id_uses_rt  in  1  The ID instruction reads rt.
- ex_mem_read  in  1  The EX instruction is a load.
- ex_reg_write  in  1  The EX instruction writes a register.
- ex_rd  in  5  Destination register of the EX instruction.
- ex_branch_taken  in  1  A branch/jump resolved taken in EX.
- ex_mdu_start  in  1  The EX instruction is a mult/div; level signal, held while EX is frozen.
- mem_access  in  1  The MEM stage performs a load or store.
- dmem_ready  in  1  Data memory completes this cycle.
- imem_ready  in  1  Instruction memory returns a valid fetch this cycle.
- pc_ce  out  1  PC update enable.
- ifid_ce  out  1  IF/ID enable.
- ifid_flush  out  1  IF/ID synchronous clear; ORed with rst at the register.
- idex_ce  out  1  ID/EX enable.
- idex_flush  out  1  ID/EX clear (inserts a bubble).
- exmem_ce  out  1  EX/MEM enable.
- exmem_flush  out  1  EX/MEM clear.
- memwb_flush  out  1  MEM/WB clear.
- mdu_busy  out  1  FSM is in the MDU state.
- mdu_done  out  1  One-cycle pulse: the MDU result is valid and the op leaves EX.
- stall_cycles  out  CNT_W  Count of cycles with pc_ce=0.

Behaviour:
- Control outputs are combinational from the inputs and registered state. State (fsm, cnt, done_q, stall_cycles) updates on posedge clk.
- Default, with no hazard: all *_ce=1, all *_flush=0.
- While rst=1:
  - All *_ce=0, all *_flush=1, mdu_busy=0, mdu_done=0.
  - Next state: fsm=RUN, cnt=0, done_q=0, stall_cycles=0.
- Priority, highest first. Only the highest active condition shapes the outputs.
- 1. dmem_stall = mem_access & ~dmem_ready.
  - pc_ce=ifid_ce=idex_ce=exmem_ce=0, memwb_flush=1. All other flushes are 0.
  - FSM, cnt and done_q hold.
  - Any branch or load-use is deferred, not lost, because its stage is held.
- 2. mdu_stall = (fsm==MDU) | (fsm==RUN & ex_mdu_start & ~done_q).
  - pc_ce=ifid_ce=idex_ce=0, exmem_ce=1, exmem_flush=1 (bubble into MEM).
- 3. ex_branch_taken:
  - pc_ce=1 (redirect wins even if imem_ready=0), ifid_flush=1, idex_flush=1.
  - Load-use in the same cycle is ignored, because the ID instruction is squashed.
- 4. load_use = ex_mem_read & ex_reg_write & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - pc_ce=0, ifid_ce=0, idex_flush=1.
  - Exactly one bubble; no state is kept.
- 5. ~imem_ready: pc_ce=0, ifid_flush=1 (bubble into ID). The rest of the pipeline runs.
- FSM states: RUN and MDU.
  - RUN → MDU when ex_mdu_start & ~done_q & ~dmem_stall. Load cnt=MDU_LAT-1.
  - In MDU with no dmem_stall: cnt<=cnt-1. When cnt==1, go to RUN and set done_q=1.
  - done_q clears after one cycle, unless dmem_stall holds it.
  - While done_q=1, ex_mdu_start is ignored, so the held instruction advances without retriggering.
  - mdu_done = done_q & ~rst.
- MDU timing:
  - Total front-end stall per op = MDU_LAT cycles, plus any dmem_stall cycles.
  - EX occupancy = MDU_LAT+1 cycles.
- mdu_busy = (fsm==MDU).
- stall_cycles increments when pc_ce==0 and rst==0. It saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-MDU: the FSM returns to RUN, and the op is discarded with no done pulse.

Decomposition:
- Shared package `pipe_ctrl_pkg`:
  - FSM state encoding (RUN=1'b0, MDU=1'b1).
  - REG_W=5.
  - Constant REG_ZERO=5'd0.
- One natural sub-module: `hazard_detect`. It is the combinational load_use comparator. The forwarding unit reuses it.
- The FSM, priority mux and counter stay in the top.

Test Plan:
- rst=1 for 2 cycles, then release with idle inputs → during reset all ce=0 and flush=1; after release all ce=1, flush=0, stall_cycles=0.
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5'd8, id_rs=8, id_uses_rs=1 → one cycle of pc_ce=0, ifid_ce=0, idex_flush=1; ex_rd=0 gives no stall; stall_cycles=1.
- MDU with MDU_LAT=4: ex_mdu_start held 1 →
  - pc_ce=0 for exactly 4 cycles;
  - mdu_busy=1 for cycles 2–4;
  - mdu_done pulses in cycle 5, with all ce=1 and no retrigger.
- Branch with load-use and imem_ready=0 in the same cycle → pc_ce=1, ifid_flush=1, idex_flush=1, ifid_ce=1.
- dmem_ready=0 for 3 cycles during the MDU state (cnt=2) → all ce=0, memwb_flush=1, cnt holds at 2; MDU completes 3 cycles later than nominal.
- Saturation, using a parameter override CNT_W=3: hold imem_ready=0 for 10 cycles → stall_cycles reaches 7 and stays at 7. Also assert rst during the MDU state → next cycle mdu_busy=0, with no mdu_done pulse.
